// File: rtl/pmem_arbiter_pkg.sv
// Shared types and constants for the physical-memory port arbiter.
// The grant and state encodings are used by the top and by the priority block.
package pmem_arbiter_pkg;

    localparam int PMEM_LINE_OFFSET = 4;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_L2_READ,
        GNT_L2_WRITE,
        GNT_VC
    } grant_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY,
        ARB_RELEASE
    } arb_state_t;

    function automatic logic is_l2_grant(grant_t g);
        return (g == GNT_L2_READ) || (g == GNT_L2_WRITE);
    endfunction

endpackage

// File: rtl/pmem_arb_priority.sv
// Combinational grant selection: starvation promotion, same-line hazard
// override, then fixed priority L2 read > L2 write > VC writeback.
module pmem_arb_priority
    import pmem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int OFFSET_BITS = PMEM_LINE_OFFSET
) (
    input  logic                  l2_read_i,
    input  logic                  l2_write_i,
    input  logic                  vc_write_i,
    input  logic [ADDR_WIDTH-1:0] l2_address_i,
    input  logic [ADDR_WIDTH-1:0] vc_address_i,
    input  logic                  starved_i,
    output logic [1:0]            grant_o
);

    logic   same_line;
    grant_t grant;

    assign same_line = (l2_address_i[ADDR_WIDTH-1:OFFSET_BITS] ==
                        vc_address_i[ADDR_WIDTH-1:OFFSET_BITS]);

    always_comb begin
        // NOTE: default assignment first so every path assigns grant; no latch is inferred.
        grant = GNT_NONE;
        if (vc_write_i && starved_i) begin
            grant = GNT_VC;
        end else if (vc_write_i && l2_read_i && same_line) begin
            // The victim line must reach pmem before L2 refetches it.
            grant = GNT_VC;
        end else if (l2_read_i) begin
            grant = GNT_L2_READ;
        end else if (l2_write_i) begin
            grant = GNT_L2_WRITE;
        end else if (vc_write_i) begin
            grant = GNT_VC;
        end
    end

    assign grant_o = grant;

endmodule

// File: rtl/pmem_arbiter.sv
// Arbitrates the single pmem port between L2 fill, L2 eviction and victim-cache
// writeback; IDLE -> BUSY (until pmem_resp) -> RELEASE -> IDLE.
module pmem_arbiter
    import pmem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = 16,
    parameter int LINE_WIDTH   = 128,
    parameter int OFFSET_BITS  = PMEM_LINE_OFFSET,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  l2_read,
    input  logic                  l2_write,
    input  logic [ADDR_WIDTH-1:0] l2_address,
    input  logic [LINE_WIDTH-1:0] l2_wdata,
    output logic                  l2_resp,
    output logic [LINE_WIDTH-1:0] l2_rdata,
    input  logic                  vc_write,
    input  logic [ADDR_WIDTH-1:0] vc_address,
    input  logic [LINE_WIDTH-1:0] vc_wdata,
    output logic                  vc_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp,
    output logic                  l2_pmem_busy
);

    localparam int                CNT_W      = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]  STARVE_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_t       state_q;
    grant_t           grant_q;
    grant_t           next_grant;
    logic [1:0]       next_grant_raw;
    logic             pmem_read_q;
    logic             pmem_write_q;
    logic [CNT_W-1:0] starve_q;
    logic [CNT_W-1:0] starve_d;
    logic             starved;
    logic             in_busy;
    logic             l2_granted;

    assign starved    = (starve_q >= STARVE_MAX);
    assign in_busy    = (state_q == ARB_BUSY);
    assign l2_granted = is_l2_grant(grant_q);

    pmem_arb_priority #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .OFFSET_BITS (OFFSET_BITS)
    ) u_priority (
        .l2_read_i    (l2_read),
        .l2_write_i   (l2_write),
        .vc_write_i   (vc_write),
        .l2_address_i (l2_address),
        .vc_address_i (vc_address),
        .starved_i    (starved),
        .grant_o      (next_grant_raw)
    );

    assign next_grant = grant_t'(next_grant_raw);

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            grant_q      <= GNT_NONE;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
        end else begin
            unique case (state_q)
                ARB_IDLE: begin
                    grant_q <= next_grant;
                    if (next_grant != GNT_NONE) begin
                        state_q      <= ARB_BUSY;
                        pmem_read_q  <= (next_grant == GNT_L2_READ);
                        pmem_write_q <= (next_grant == GNT_L2_WRITE) || (next_grant == GNT_VC);
                    end
                end
                ARB_BUSY: begin
                    if (pmem_resp) begin
                        state_q      <= ARB_RELEASE;
                        pmem_read_q  <= 1'b0;
                        pmem_write_q <= 1'b0;
                    end
                end
                ARB_RELEASE: begin
                    state_q <= ARB_IDLE;
                end
                default: begin
                    state_q      <= ARB_IDLE;
                    pmem_read_q  <= 1'b0;
                    pmem_write_q <= 1'b0;
                end
            endcase
        end
    end

    // Counts cycles a pending VC writeback spends behind someone else's transfer.
    always_comb begin
        starve_d = starve_q;
        if (vc_write) begin
            if (state_q == ARB_IDLE) begin
                if (next_grant == GNT_VC) begin
                    starve_d = '0;
                end else if (!starved) begin
                    starve_d = starve_q + 1'b1;
                end
            end else if ((grant_q != GNT_VC) && !starved) begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    always_comb begin
        pmem_address = '0;
        pmem_wdata   = '0;
        if (in_busy) begin
            if (grant_q == GNT_VC) begin
                pmem_address = vc_address;
                pmem_wdata   = vc_wdata;
            end else begin
                pmem_address = l2_address;
                pmem_wdata   = l2_wdata;
            end
        end
    end

    assign pmem_read    = pmem_read_q;
    assign pmem_write   = pmem_write_q;
    assign l2_resp      = in_busy && pmem_resp && l2_granted;
    assign vc_resp      = in_busy && pmem_resp && (grant_q == GNT_VC);
    assign l2_rdata     = pmem_rdata;
    assign l2_pmem_busy = l2_read || l2_write || ((state_q != ARB_IDLE) && l2_granted);

    // A simultaneous L2 read and write is a requester bug; it is served as a read.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(l2_read && l2_write));
        end
    end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed and randomized bench for pmem_arbiter; a transaction-level model of
// the arbitration rules and pmem timing supplies every expected value.
module tb_pmem_arbiter;
    import pmem_arbiter_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         l2_read, l2_write, vc_write, pmem_resp;
    logic [15:0]  l2_address, vc_address;
    logic [127:0] l2_wdata, vc_wdata, pmem_rdata;
    logic         l2_resp, vc_resp, pmem_read, pmem_write, l2_pmem_busy;
    logic [127:0] l2_rdata, pmem_wdata;
    logic [15:0]  pmem_address;

    pmem_arbiter #(
        .ADDR_WIDTH   (16),
        .LINE_WIDTH   (128),
        .OFFSET_BITS  (4),
        .STARVE_LIMIT (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .l2_read      (l2_read),
        .l2_write     (l2_write),
        .l2_address   (l2_address),
        .l2_wdata     (l2_wdata),
        .l2_resp      (l2_resp),
        .l2_rdata     (l2_rdata),
        .vc_write     (vc_write),
        .vc_address   (vc_address),
        .vc_wdata     (vc_wdata),
        .vc_resp      (vc_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .l2_pmem_busy (l2_pmem_busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: phase 0 = awaiting arbitration, 1 = pmem transfer, 2 = release gap.
    // Owner 0 none, 1 L2 read, 2 L2 write, 3 VC writeback.
    int m_ph, m_own, m_left, m_wait, lat_sel;
    bit l2_keep, rand_on, spur_on;
    bit e_l2_resp, e_vc_resp, obs_l2_resp, obs_vc_resp;
    int n;
    bit found;

    task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int pick(bit r, bit w, bit v, logic [15:0] la, logic [15:0] va, int wait_cnt);
        if (v && wait_cnt >= 8) return 3;
        if (v && r && ((la >> 4) == (va >> 4))) return 3;
        if (r) return 1;
        if (w) return 2;
        if (v) return 3;
        return 0;
    endfunction

    // One clock cycle: drive pmem, check outputs, advance model, update requesters.
    task automatic step();
        bit busy_now;
        int g;
        busy_now   = (m_ph == 1);
        pmem_resp  = busy_now ? (m_left == 1) : (spur_on && ($urandom_range(0, 3) == 0));
        pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
        #1;
        e_l2_resp   = busy_now && pmem_resp && (m_own == 1 || m_own == 2);
        e_vc_resp   = busy_now && pmem_resp && (m_own == 3);
        obs_l2_resp = l2_resp;
        obs_vc_resp = vc_resp;
        check("pmem_read", 128'(pmem_read), 128'(busy_now && m_own == 1));
        check("pmem_write", 128'(pmem_write), 128'(busy_now && m_own >= 2));
        check("pmem_address", 128'(pmem_address),
              128'(!busy_now ? 16'h0 : (m_own == 3 ? vc_address : l2_address)));
        check("pmem_wdata", pmem_wdata,
              !busy_now ? 128'h0 : (m_own == 3 ? vc_wdata : l2_wdata));
        check("l2_resp", 128'(l2_resp), 128'(e_l2_resp));
        check("vc_resp", 128'(vc_resp), 128'(e_vc_resp));
        check("l2_rdata", l2_rdata, pmem_rdata);
        check("l2_pmem_busy", 128'(l2_pmem_busy),
              128'(l2_read || l2_write || (m_ph != 0 && (m_own == 1 || m_own == 2))));
        check("starve_cnt", 128'(dut.starve_q), 128'(m_wait));

        g = 0;
        if (m_ph == 0) g = pick(l2_read, l2_write, vc_write, l2_address, vc_address, m_wait);
        if (vc_write) begin
            if (m_ph == 0 && g == 3) m_wait = 0;
            else if (!(m_ph != 0 && m_own == 3) && m_wait < 8) m_wait++;
        end
        case (m_ph)
            0: if (g != 0) begin m_own = g; m_ph = 1; m_left = lat_sel; end else m_own = 0;
            1: if (m_left == 1) m_ph = 2; else m_left--;
            default: m_ph = 0;
        endcase

        @(posedge clk);
        #1;
        if (e_l2_resp) begin
            l2_read  = 1'b0;
            l2_write = 1'b0;
        end else if (!l2_read && !l2_write) begin
            if (l2_keep) begin
                l2_read = 1'b1;
            end else if (rand_on && $urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 1) l2_read = 1'b1; else l2_write = 1'b1;
                l2_wdata = {$urandom, $urandom, $urandom, $urandom};
                if (vc_write && $urandom_range(0, 2) == 0)
                    l2_address = {vc_address[15:4], 4'($urandom)};
                else
                    l2_address = 16'($urandom);
            end
        end
        if (e_vc_resp) begin
            vc_write = 1'b0;
        end else if (!vc_write && rand_on && $urandom_range(0, 3) == 0) begin
            vc_write = 1'b1;
            vc_wdata = {$urandom, $urandom, $urandom, $urandom};
            if ((l2_read || l2_write) && $urandom_range(0, 2) == 0)
                vc_address = {l2_address[15:4], 4'($urandom)};
            else
                vc_address = 16'($urandom);
        end
        if (rand_on) lat_sel = $urandom_range(1, 4);
    endtask

    task automatic drain(string tag);
        bit done;
        done    = 1'b0;
        l2_keep = 1'b0;
        for (int i = 0; i < 80 && !done; i++) begin
            if (m_ph == 0 && !l2_read && !l2_write && !vc_write) done = 1'b1;
            else step();
        end
        check({tag, "_drained"}, 128'(done), 128'(1));
    endtask

    initial begin
        rst_n = 1'b0;
        l2_read = 1'b0; l2_write = 1'b0; vc_write = 1'b0; pmem_resp = 1'b0;
        l2_address = '0; vc_address = '0; l2_wdata = '0; vc_wdata = '0; pmem_rdata = '0;
        m_ph = 0; m_own = 0; m_left = 0; m_wait = 0; lat_sel = 1;
        l2_keep = 0; rand_on = 0; spur_on = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", 128'(dut.state_q), 128'(ARB_IDLE));
        check("rst_grant", 128'(dut.grant_q), 128'(GNT_NONE));
        check("rst_starve", 128'(dut.starve_q), 128'(0));
        check("rst_strobes", 128'({pmem_read, pmem_write, l2_resp, vc_resp, l2_pmem_busy}), 128'(0));
        check("rst_address", 128'(pmem_address), 128'(0));
        check("rst_wdata", pmem_wdata, 128'(0));
        rst_n = 1'b1;

        // Lone L2 read, pmem answers in the third busy cycle
        l2_read = 1'b1; l2_address = 16'h1230; l2_wdata = 128'h0; lat_sel = 3;
        step();
        check("t1_read_c1", 128'({pmem_read, pmem_write}), 128'(2'b10));
        check("t1_addr_c1", 128'(pmem_address), 128'(16'h1230));
        step();
        step();
        step();
        check("t1_resp_c3", 128'(obs_l2_resp), 128'(1));
        check("t1_release_c4", 128'(dut.state_q), 128'(ARB_RELEASE));
        drain("t1");
        check("busy_idle", 128'(l2_pmem_busy), 128'(0));

        // L2 write and VC writeback together: L2 first, VC after the release gap
        l2_write = 1'b1; l2_address = 16'h2000; l2_wdata = {4{32'hA5A5_0001}};
        vc_write = 1'b1; vc_address = 16'h4000; vc_wdata = {4{32'h5A5A_0002}};
        lat_sel = 2;
        step();
        check("t2_first_addr", 128'(pmem_address), 128'(16'h2000));
        step();
        step();
        check("t2_l2_resp", 128'({obs_l2_resp, obs_vc_resp}), 128'(2'b10));
        step();
        step();
        check("t2_vc_addr", 128'(pmem_address), 128'(16'h4000));
        check("t2_vc_busy0", 128'(l2_pmem_busy), 128'(0));
        step();
        step();
        check("t2_vc_resp", 128'({obs_l2_resp, obs_vc_resp}), 128'(2'b01));
        drain("t2");

        // VC held while L2 reads arrive back-to-back: starvation promotion
        vc_write = 1'b1; vc_address = 16'h7000; vc_wdata = {4{32'h0BAD_F00D}};
        l2_read = 1'b1; l2_address = 16'h1000; l2_keep = 1'b1; lat_sel = 1;
        n = 0; found = 1'b0;
        for (int i = 1; i <= 40 && !found; i++) begin
            step();
            if (pmem_write) begin found = 1'b1; n = i; end
        end
        check("t3_vc_cycle", 128'(n), 128'(10));
        check("t3_cnt_cleared", 128'(dut.starve_q), 128'(0));
        drain("t3");

        // Same-line hazard: VC write goes first
        l2_read = 1'b1; l2_address = 16'h5238;
        vc_write = 1'b1; vc_address = 16'h5230; lat_sel = 2;
        step();
        check("t4_hazard_vc_first", 128'({pmem_write, pmem_address}), 128'({1'b1, 16'h5230}));
        drain("t4a");

        // Different line: the read goes first
        l2_read = 1'b1; l2_address = 16'h5240;
        vc_write = 1'b1; vc_address = 16'h5230; lat_sel = 2;
        step();
        check("t4_no_hazard_read_first", 128'({pmem_read, pmem_address}), 128'({1'b1, 16'h5240}));
        drain("t4b");

        // Reset while a transfer is in flight
        l2_read = 1'b1; l2_address = 16'h3330;
        vc_write = 1'b1; vc_address = 16'h6000; lat_sel = 4;
        step();
        step();
        rst_n = 1'b0; l2_read = 1'b0; vc_write = 1'b0; pmem_resp = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_ph = 0; m_own = 0; m_left = 0; m_wait = 0;
        check("t5_state_idle", 128'(dut.state_q), 128'(ARB_IDLE));
        check("t5_strobes", 128'({pmem_read, pmem_write}), 128'(0));
        check("t5_cnt", 128'(dut.starve_q), 128'(0));
        l2_read = 1'b1; l2_address = 16'h3340; lat_sel = 2;
        step();
        check("t5_fresh_read", 128'({pmem_read, pmem_address}), 128'({1'b1, 16'h3340}));
        drain("t5");

        // Randomized traffic with stray pmem_resp pulses outside transfers
        rand_on = 1'b1; spur_on = 1'b1;
        repeat (1500) step();
        rand_on = 1'b0;
        drain("rand");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pmem_arbiter.md
Name: pmem_arbiter

Overview:
- Shares the single physical-memory port between three line-sized requesters: L2 miss fill (read), L2 dirty eviction (write), victim-cache writeback (write).
- Sits between the L2/victim-cache pair and pmem.
- Fixed priority with a starvation guard for the victim cache, plus a same-line hazard override.
- Drives the L2-to-pmem busy indication consumed by the victim-cache controller for idle-time cleanup.

Parameters:
- ADDR_WIDTH, 16, byte address width.
- LINE_WIDTH, 128, cache line width in bits.
- OFFSET_BITS, 4, line offset bits ignored in address compare.
- STARVE_LIMIT, 8, waiting cycles after which VC writeback is promoted to top priority.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- l2_read  in  1  L2 fill request
- l2_write  in  1  L2 eviction request
- l2_address  in  ADDR_WIDTH  L2 request line address
- l2_wdata  in  LINE_WIDTH  L2 eviction data
- l2_resp  out  1  L2 request complete, one cycle
- l2_rdata  out  LINE_WIDTH  fill data, valid with l2_resp
- vc_write  in  1  VC writeback request
- vc_address  in  ADDR_WIDTH  VC writeback line address
- vc_wdata  in  LINE_WIDTH  VC writeback data
- vc_resp  out  1  VC writeback complete, one cycle
- pmem_read  out  1  pmem read strobe
- pmem_write  out  1  pmem write strobe
- pmem_address  out  ADDR_WIDTH  pmem line address
- pmem_wdata  out  LINE_WIDTH  pmem write data
- pmem_rdata  in  LINE_WIDTH  pmem read data
- pmem_resp  in  1  pmem transaction complete
- l2_pmem_busy  out  1  L2 path occupies or wants pmem

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset values: state IDLE, grant NONE, starve counter 0; all outputs 0 (pmem_address and pmem_wdata included).
- States:
  - IDLE: arbitrate among asserted requests. If any request is asserted, latch the grant and go to BUSY at the next edge. Nothing is driven to pmem while in IDLE.
  - BUSY: drive pmem_read or pmem_write per the latched grant. pmem_address and pmem_wdata are muxed from the granted requester's inputs. Stay until pmem_resp.
    - On the pmem_resp cycle, assert the granted requester's resp combinationally, the same cycle.
    - l2_rdata = pmem_rdata, passed through unconditionally.
    - Next state is RELEASE.
  - RELEASE: one cycle; all pmem strobes and resps are 0. Lets the requester drop or change its request. Return to IDLE.
- Latency: a request seen in IDLE at cycle t drives its pmem strobe at t+1. Minimum turnaround is pmem latency + 2 cycles.
- Priority, highest first:
  - VC, if starve count >= STARVE_LIMIT.
  - VC, if l2_read is asserted and vc_write is asserted with an equal line address (ADDR_WIDTH-1:OFFSET_BITS). The hazard rule prevents reading a stale line from pmem.
  - l2_read.
  - l2_write.
  - vc_write.
- Simultaneous l2_read and l2_write is illegal; treat it as l2_read and flag it with an assertion.
- Starve counter:
  - Increments in IDLE when vc_write is asserted but not granted.
  - Also increments in BUSY/RELEASE while vc_write is asserted and the grant is not VC.
  - Saturates at STARVE_LIMIT.
  - Clears to 0 on the cycle VC is granted.
  - Width is $clog2(STARVE_LIMIT+1).
- Requesters hold request, address and data stable until their resp. A deassertion mid-BUSY is a protocol violation: the arbiter still completes the pmem transaction and the bench asserts on it.
- l2_pmem_busy = l2_read | l2_write | (state != IDLE && grant is L2). It is combinational. VC cleanup only starts when it is 0.
- pmem_resp outside BUSY is ignored.
- Reset mid-BUSY: next edge returns to IDLE with strobes 0. The in-flight pmem transaction is abandoned; pmem is reset concurrently.

Decomposition:
- Shared package additions:
  - grant_t enum {GNT_NONE, GNT_L2_READ, GNT_L2_WRITE, GNT_VC}.
  - arb_state_t enum {ARB_IDLE, ARB_BUSY, ARB_RELEASE}.
  - Constant PMEM_LINE_OFFSET = 4.
- One sub-module: pmem_arb_priority. It is combinational and computes the next grant from the requests, the hazard compare and the starve flag. This isolates the priority rule for unit testing.
- FSM, counter and muxes live in the top.

Test Plan:
- Lone l2_read @0x1230, pmem_resp after 3 cycles:
  - pmem_read high cycles 1–3 with pmem_address 0x1230.
  - l2_resp and l2_rdata valid in cycle 3.
  - RELEASE in cycle 4.
- l2_write @0x2000 and vc_write @0x4000 together:
  - L2 is granted first.
  - VC is granted after RELEASE.
  - vc_resp on VC's pmem_resp only.
- vc_write held while l2_read requests arrive back-to-back:
  - VC is granted no later than the first arbitration with starve count = 8.
  - Counter reads 0 the cycle after the VC grant.
- l2_read @0x5238 and vc_write @0x5230 together (same line):
  - VC write is issued first, then the L2 read.
  - With l2_read @0x5240 instead, the read goes first.
- Drop rst_n during BUSY:
  - State IDLE, all strobes 0 and counter 0 at the next edge.
  - A fresh l2_read after release proceeds normally.
- l2_pmem_busy:
  - 0 when idle.
  - 1 while l2_read is pending, and through an L2 grant until RELEASE ends.
  - 0 during a VC grant.
